correlator_accum: RTL
=====================

# correlator_accum

Per-channel correlation accumulator sitting directly downstream of `code_gen` in each tracking channel. It multiplies the carrier-wiped baseband I/Q samples by the early, prompt and late code replicas and integrates the six products over one code period. On `dump_enable` it latches the six sums to software-visible registers, restarts integration and flags new data for the channel's bus/interrupt logic.

## Interface
Parameters:
- `BB_W`, 3: signed width of baseband I/Q samples (mixer output).
- `ACC_W`, 16: signed width of accumulators and output registers.

Ports:
- `clk`  in  1  system clock (16.368 MHz).
- `rstn`  in  1  reset, synchronous, active-low.
- `sample_enable`  in  1  qualifies `i_bb`/`q_bb` as a new sample.
- `i_bb`, `q_bb`  in  BB_W each  signed baseband samples.
- `early`, `prompt`, `late`  in  1 each  code chips from `code_gen`; 1 → +1, 0 → −1.
- `dump_enable`  in  1  one-cycle pulse from `code_gen` at code-period boundary.
- `status_read`  in  1  one-cycle pulse; software has read the status.
- `i_early`, `q_early`, `i_prompt`, `q_prompt`, `i_late`, `q_late`  out  ACC_W each  dumped sums.
- `accum_ready`  out  1  new dump available.
- `accum_overrun`  out  1  sticky; dump occurred while `accum_ready` was still set.

## Operation
- Six running accumulators, one per {I,Q}×{E,P,L}.
- Product: chip=1 → +sample, chip=0 → −sample. The most negative sample (−2^(BB_W−1)) negated is +2^(BB_W−1), computed at BB_W+1 bits, with no wrap.
- With `sample_enable`=1, each accumulator adds its product with signed saturation to [−2^(ACC_W−1), 2^(ACC_W−1)−1]. Saturation is per lane and does not wrap.
- With `sample_enable`=0, the accumulators hold.
- On `dump_enable`=1:
  - Each output register loads accumulator + the coincident product (product only if `sample_enable`=1), saturated.
  - Accumulators clear to 0. The coincident sample belongs to the ending period and is not carried into the next one.
- Status flags:
  - `accum_ready`: set on dump; cleared on `status_read`. When both occur in the same cycle, set wins.
  - `accum_overrun`: set on dump while `accum_ready`=1; cleared on `status_read`. When both occur in the same cycle, set wins.
  - Flags change only on these events.
- Output registers change only on dump.

## Timing
- Reset (rstn=0 at a clk edge): all accumulators, all six outputs, `accum_ready` and `accum_overrun` are 0 on the following cycle. Reset mid-period discards the partial sum. An input pulse coincident with reset is ignored.
- Accumulate latency: a sample is included in the accumulator on the edge where `sample_enable`=1.
- Dump latency: outputs and `accum_ready` are valid on the cycle after the `dump_enable` edge, and are stable until the next dump.
- `dump_enable` on consecutive cycles is legal:
  - The second dump contains only the product of the second cycle, or 0 if no sample.
  - Overrun sets unless a read intervened.
- Chip inputs are sampled on the same edge as the sample. No internal delay is applied: `code_gen` aligns E/P/L itself.

## Structure
- Package `correlator_pkg`:
  - default `BB_W`/`ACC_W` localparams.
  - function `sat_add(acc, prod)` returning an ACC_W-bit saturated sum.
  - function `chip_mul(sample, chip)` returning a BB_W+1-bit product.
- Sub-module `accum_lane`:
  - ports: `clk`, `rstn`, `sample_enable`, `dump_enable`, `sample`, `chip`, `dump_val`.
  - Instantiated six times.
- Status flag logic lives in the top level.

## Test plan
- Reset: drive arbitrary inputs with rstn=0 → all outputs and flags 0. Release, then apply `i_bb`=+1, `prompt`=1 for 2046 samples, then dump → `i_prompt`=2046, `i_early`=2046 if early=1. `accum_ready`=1 one cycle after the dump.
- Sign and negative extreme: `i_bb`=−4, `q_bb`=+3, `late`=0 for 10 samples, then dump → `i_late`=+40, `q_late`=−30.
- Saturation: `i_bb`=+3, prompt=1 for 12000 samples → `i_prompt`=32767. `q_bb`=−4, prompt=1 for 12000 samples → `q_prompt`=−32768.
- Coincident dump/sample: 5 samples of +1, then a 6th sample concurrent with `dump_enable`, then 3 more samples and a dump → first dump 6, second dump 3.
- Flags: two dumps with no read → `accum_overrun`=1. `status_read` alone → both flags 0. `status_read` concurrent with a dump → `accum_ready`=1, `accum_overrun` unchanged-set rule applied.
- Reset mid-period: 1000 samples of +1, rstn=0 for one cycle, 7 samples, then dump → output 7, `accum_overrun`=0.

Source files
------------

// File: rtl/correlator_pkg.sv
// Shared widths and arithmetic helpers for the per-channel correlator.
package correlator_pkg;

  localparam int BB_W_DEF  = 3;
  localparam int ACC_W_DEF = 16;

  // Signed add of an accumulator and a product, clamped to the accumulator
  // range instead of wrapping.
  function automatic logic signed [ACC_W_DEF-1:0] sat_add(
    input logic signed [ACC_W_DEF-1:0] acc,
    input logic signed [BB_W_DEF:0]    prod
  );
    logic signed [ACC_W_DEF:0]   sum;
    logic signed [ACC_W_DEF-1:0] res;
    sum = {acc[ACC_W_DEF-1], acc}
        + {{(ACC_W_DEF-BB_W_DEF){prod[BB_W_DEF]}}, prod};
    if (sum[ACC_W_DEF] != sum[ACC_W_DEF-1]) begin
      res = sum[ACC_W_DEF] ? {1'b1, {(ACC_W_DEF-1){1'b0}}}
                           : {1'b0, {(ACC_W_DEF-1){1'b1}}};
    end else begin
      res = sum[ACC_W_DEF-1:0];
    end
    return res;
  endfunction

  // Chip 1 passes the sample, chip 0 negates it. One extra bit keeps the
  // negated most-negative sample representable.
  function automatic logic signed [BB_W_DEF:0] chip_mul(
    input logic signed [BB_W_DEF-1:0] sample,
    input logic                       chip
  );
    logic signed [BB_W_DEF:0] ext;
    ext = {sample[BB_W_DEF-1], sample};
    return chip ? ext : -ext;
  endfunction

endpackage

// File: rtl/correlator_accum_lane.sv
// One correlation lane: sample x chip, saturating integrate, dump register.
module accum_lane
  import correlator_pkg::*;
#(
  parameter int BB_W  = BB_W_DEF,
  parameter int ACC_W = ACC_W_DEF
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             sample_enable,
  input  logic             dump_enable,
  input  logic [BB_W-1:0]  sample,
  input  logic             chip,
  output logic [ACC_W-1:0] dump_val
);

  logic signed [BB_W:0]    prod;
  logic signed [ACC_W-1:0] sum;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic signed [ACC_W-1:0] dump_q, dump_d;

  // Next accumulator / dump value; a coincident sample closes the old period.
  always_comb begin
    prod   = chip_mul($signed(sample), chip);
    sum    = sample_enable ? sat_add(acc_q, prod) : acc_q;
    acc_d  = sum;
    dump_d = dump_q;
    if (dump_enable) begin
      dump_d = sum;
      acc_d  = '0;
    end
  end

  // Lane state registers.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      acc_q  <= '0;
      dump_q <= '0;
    end else begin
      acc_q  <= acc_d;
      dump_q <= dump_d;
    end
  end

  assign dump_val = dump_q;

endmodule

// File: rtl/correlator_accum.sv
// Early/prompt/late I/Q correlation accumulator with dump status flags.
module correlator_accum
  import correlator_pkg::*;
#(
  parameter int BB_W  = BB_W_DEF,
  parameter int ACC_W = ACC_W_DEF
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             sample_enable,
  input  logic [BB_W-1:0]  i_bb,
  input  logic [BB_W-1:0]  q_bb,
  input  logic             early,
  input  logic             prompt,
  input  logic             late,
  input  logic             dump_enable,
  input  logic             status_read,
  output logic [ACC_W-1:0] i_early,
  output logic [ACC_W-1:0] q_early,
  output logic [ACC_W-1:0] i_prompt,
  output logic [ACC_W-1:0] q_prompt,
  output logic [ACC_W-1:0] i_late,
  output logic [ACC_W-1:0] q_late,
  output logic             accum_ready,
  output logic             accum_overrun
);

  // Lane order: even lanes take I, odd lanes take Q; pairs are E, P, L.
  logic [BB_W-1:0]  lane_sample [6];
  logic             lane_chip   [6];
  logic [ACC_W-1:0] lane_dump   [6];

  assign lane_sample[0] = i_bb;
  assign lane_sample[1] = q_bb;
  assign lane_sample[2] = i_bb;
  assign lane_sample[3] = q_bb;
  assign lane_sample[4] = i_bb;
  assign lane_sample[5] = q_bb;
  assign lane_chip[0]   = early;
  assign lane_chip[1]   = early;
  assign lane_chip[2]   = prompt;
  assign lane_chip[3]   = prompt;
  assign lane_chip[4]   = late;
  assign lane_chip[5]   = late;

  for (genvar k = 0; k < 6; k++) begin : g_lane
    accum_lane #(
      .BB_W  (BB_W),
      .ACC_W (ACC_W)
    ) u_lane (
      .clk           (clk),
      .rstn          (rstn),
      .sample_enable (sample_enable),
      .dump_enable   (dump_enable),
      .sample        (lane_sample[k]),
      .chip          (lane_chip[k]),
      .dump_val      (lane_dump[k])
    );
  end

  assign i_early  = lane_dump[0];
  assign q_early  = lane_dump[1];
  assign i_prompt = lane_dump[2];
  assign q_prompt = lane_dump[3];
  assign i_late   = lane_dump[4];
  assign q_late   = lane_dump[5];

  logic ready_q, ready_d;
  logic overrun_q, overrun_d;

  // Flag next state: a dump outranks a read in the same cycle.
  always_comb begin
    ready_d   = ready_q;
    overrun_d = overrun_q;
    if (status_read) begin
      ready_d   = 1'b0;
      overrun_d = 1'b0;
    end
    if (dump_enable) begin
      ready_d = 1'b1;
      if (ready_q) overrun_d = 1'b1;
    end
  end

  // Flag registers.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      ready_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      ready_q   <= ready_d;
      overrun_q <= overrun_d;
    end
  end

  assign accum_ready   = ready_q;
  assign accum_overrun = overrun_q;

endmodule
